// File: rtl/pipeline_one_if.sv
// rtl/pipeline_one_if.sv - link and stage-two handshake bundle for pipeline_one (four ports n/s/e/w).
// Stats outputs exist only when PIPELINE_ONE_STATS_EN is defined.
interface pipeline_one_if;
  logic [9:0] n_in, s_in, e_in, w_in;
  logic       n_in_vld, s_in_vld, e_in_vld, w_in_vld;
  logic       n_in_rdy, s_in_rdy, e_in_rdy, w_in_rdy;
  logic [9:0] nty, sty, ety, wty;
  logic [2:0] n_route, s_route, e_route, w_route;
  logic       n_out_vld, s_out_vld, e_out_vld, w_out_vld;
  logic       n_out_rdy, s_out_rdy, e_out_rdy, w_out_rdy;
`ifdef PIPELINE_ONE_STATS_EN
  logic [15:0] n_fwd_cnt, s_fwd_cnt, e_fwd_cnt, w_fwd_cnt;
`endif

  modport master (
    output n_in, s_in, e_in, w_in,
    output n_in_vld, s_in_vld, e_in_vld, w_in_vld,
    input  n_in_rdy, s_in_rdy, e_in_rdy, w_in_rdy,
    input  nty, sty, ety, wty,
    input  n_route, s_route, e_route, w_route,
    input  n_out_vld, s_out_vld, e_out_vld, w_out_vld,
`ifdef PIPELINE_ONE_STATS_EN
    input  n_fwd_cnt, s_fwd_cnt, e_fwd_cnt, w_fwd_cnt,
`endif
    output n_out_rdy, s_out_rdy, e_out_rdy, w_out_rdy
  );

  modport slave (
    input  n_in, s_in, e_in, w_in,
    input  n_in_vld, s_in_vld, e_in_vld, w_in_vld,
    output n_in_rdy, s_in_rdy, e_in_rdy, w_in_rdy,
    output nty, sty, ety, wty,
    output n_route, s_route, e_route, w_route,
    output n_out_vld, s_out_vld, e_out_vld, w_out_vld,
`ifdef PIPELINE_ONE_STATS_EN
    output n_fwd_cnt, s_fwd_cnt, e_fwd_cnt, w_fwd_cnt,
`endif
    input  n_out_rdy, s_out_rdy, e_out_rdy, w_out_rdy
  );
endinterface

// File: rtl/pipeline_one.sv
// rtl/pipeline_one.sv - router input stage: per-port FIFO, XY route tag, registered output to stage two.
// Optional per-port forward counters under PIPELINE_ONE_STATS_EN.
module pipeline_one #(
  parameter int MY_X  = 1,
  parameter int MY_Y  = 1,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  pipeline_one_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [1:0]  MX       = 2'(MY_X);
  localparam logic [1:0]  MYY      = 2'(MY_Y);

  localparam logic [2:0] R_NORTH = 3'd0;
  localparam logic [2:0] R_SOUTH = 3'd1;
  localparam logic [2:0] R_EAST  = 3'd2;
  localparam logic [2:0] R_WEST  = 3'd3;
  localparam logic [2:0] R_LOCAL = 3'd4;

  function automatic logic [2:0] xy_route(input logic [9:0] flit);
    logic [1:0] dx;
    logic [1:0] dy;
    dx = flit[9:8];
    dy = flit[7:6];
    if (dx > MX)       xy_route = R_EAST;
    else if (dx < MX)  xy_route = R_WEST;
    else if (dy > MYY) xy_route = R_NORTH;
    else if (dy < MYY) xy_route = R_SOUTH;
    else               xy_route = R_LOCAL;
  endfunction

  // Port index order everywhere: 0 = n, 1 = s, 2 = e, 3 = w
  logic [9:0]  in_flit [4];
  logic        in_vld  [4];
  logic        in_rdy  [4];
  logic [9:0]  out_flit[4];
  logic [2:0]  out_rte [4];
  logic        out_vld [4];
  logic        out_rdy [4];

  assign in_flit[0] = bus.n_in;     assign in_flit[1] = bus.s_in;
  assign in_flit[2] = bus.e_in;     assign in_flit[3] = bus.w_in;
  assign in_vld[0]  = bus.n_in_vld; assign in_vld[1]  = bus.s_in_vld;
  assign in_vld[2]  = bus.e_in_vld; assign in_vld[3]  = bus.w_in_vld;
  assign out_rdy[0] = bus.n_out_rdy; assign out_rdy[1] = bus.s_out_rdy;
  assign out_rdy[2] = bus.e_out_rdy; assign out_rdy[3] = bus.w_out_rdy;

  assign bus.n_in_rdy  = in_rdy[0];   assign bus.s_in_rdy  = in_rdy[1];
  assign bus.e_in_rdy  = in_rdy[2];   assign bus.w_in_rdy  = in_rdy[3];
  assign bus.nty       = out_flit[0]; assign bus.sty       = out_flit[1];
  assign bus.ety       = out_flit[2]; assign bus.wty       = out_flit[3];
  assign bus.n_route   = out_rte[0];  assign bus.s_route   = out_rte[1];
  assign bus.e_route   = out_rte[2];  assign bus.w_route   = out_rte[3];
  assign bus.n_out_vld = out_vld[0];  assign bus.s_out_vld = out_vld[1];
  assign bus.e_out_vld = out_vld[2];  assign bus.w_out_vld = out_vld[3];

`ifdef PIPELINE_ONE_STATS_EN
  logic [15:0] fwd_cnt[4];
  assign bus.n_fwd_cnt = fwd_cnt[0]; assign bus.s_fwd_cnt = fwd_cnt[1];
  assign bus.e_fwd_cnt = fwd_cnt[2]; assign bus.w_fwd_cnt = fwd_cnt[3];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_port
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [9:0]    flit_q;
    logic [2:0]    route_q;
    logic          vld_q;
    logic          push;
    logic          pop;

    // rst_n gating keeps in_rdy low for the whole reset, not just after the first edge
    assign in_rdy[g] = rst_n && (count != FULL_CNT);
    assign push      = in_vld[g] && in_rdy[g];
    assign pop       = (count != '0) && (!vld_q || out_rdy[g]);

    always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_flit[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end

    // Drain leaves flit/route as-is; only the valid flag drops
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        flit_q  <= '0;
        route_q <= '0;
        vld_q   <= 1'b0;
      end else if (pop) begin
        flit_q  <= mem[rptr];
        route_q <= xy_route(mem[rptr]);
        vld_q   <= 1'b1;
      end else if (out_rdy[g]) begin
        vld_q   <= 1'b0;
      end
    end

    assign out_flit[g] = flit_q;
    assign out_rte[g]  = route_q;
    assign out_vld[g]  = vld_q;

`ifdef PIPELINE_ONE_STATS_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (vld_q && out_rdy[g] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign fwd_cnt[g] = cnt_q;
`endif
  end
endmodule

// File: tb/tb_pipeline_one.sv
// tb/tb_pipeline_one.sv - scoreboard bench for pipeline_one with randomized and directed traffic.
module tb_pipeline_one;
  localparam int MY_X  = 1;
  localparam int MY_Y  = 1;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_one_if bus();
  pipeline_one #(.MY_X(MY_X), .MY_Y(MY_Y), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [9:0] tin  [4];
  logic       tvld [4];
  logic       tordy[4];
  logic       tirdy[4];
  logic [9:0] tty  [4];
  logic [2:0] trte [4];
  logic       tovld[4];

  assign bus.n_in = tin[0];  assign bus.s_in = tin[1];  assign bus.e_in = tin[2];  assign bus.w_in = tin[3];
  assign bus.n_in_vld = tvld[0]; assign bus.s_in_vld = tvld[1];
  assign bus.e_in_vld = tvld[2]; assign bus.w_in_vld = tvld[3];
  assign bus.n_out_rdy = tordy[0]; assign bus.s_out_rdy = tordy[1];
  assign bus.e_out_rdy = tordy[2]; assign bus.w_out_rdy = tordy[3];
  assign tirdy[0] = bus.n_in_rdy;  assign tirdy[1] = bus.s_in_rdy;
  assign tirdy[2] = bus.e_in_rdy;  assign tirdy[3] = bus.w_in_rdy;
  assign tty[0] = bus.nty; assign tty[1] = bus.sty; assign tty[2] = bus.ety; assign tty[3] = bus.wty;
  assign trte[0] = bus.n_route; assign trte[1] = bus.s_route;
  assign trte[2] = bus.e_route; assign trte[3] = bus.w_route;
  assign tovld[0] = bus.n_out_vld; assign tovld[1] = bus.s_out_vld;
  assign tovld[2] = bus.e_out_vld; assign tovld[3] = bus.w_out_vld;
`ifdef PIPELINE_ONE_STATS_EN
  logic [15:0] tfwd[4];
  assign tfwd[0] = bus.n_fwd_cnt; assign tfwd[1] = bus.s_fwd_cnt;
  assign tfwd[2] = bus.e_fwd_cnt; assign tfwd[3] = bus.w_fwd_cnt;
`endif

  typedef struct {
    logic [9:0] f;
    logic [2:0] r;
    int         cyc;
  } exp_t;

  exp_t exp_q[4][$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  bit   chk_lat = 1'b0;
  int   out_cnt[4] = '{0, 0, 0, 0};
  bit   acc[4];

  always @(posedge clk) cycle <= cycle + 1;

  // Reference XY routing straight from the coordinate rules
  function automatic logic [2:0] ref_route(input logic [9:0] f);
    int dx;
    int dy;
    dx = int'(f[9:8]);
    dy = int'(f[7:6]);
    if (dx > MY_X) return 3'd2;
    if (dx < MY_X) return 3'd3;
    if (dy > MY_Y) return 3'd0;
    if (dy < MY_Y) return 3'd1;
    return 3'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    #2;
    if (rst_n) begin
      for (int p = 0; p < 4; p++) begin
        if (tovld[p] && tordy[p]) begin : hs
          exp_t e;
          out_cnt[p]++;
          if (exp_q[p].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out p%0d: got flit %0h, required none", p, tty[p]);
          end else begin
            e = exp_q[p].pop_front();
            chk($sformatf("flit_p%0d", p), 32'(tty[p]), 32'(e.f));
            chk($sformatf("route_p%0d", p), 32'(trte[p]), 32'(e.r));
            if (chk_lat) chk($sformatf("latency_p%0d", p), 32'(cycle - e.cyc), 32'd1);
          end
        end
      end
    end
  end

  // Called at a negedge with inputs set; records accepted flits then advances one cycle
  task automatic tick();
    #1;
    for (int p = 0; p < 4; p++) begin : rec
      exp_t e;
      acc[p] = 1'b0;
      if (tvld[p] && tirdy[p]) begin
        e.f   = tin[p];
        e.r   = ref_route(tin[p]);
        e.cyc = cycle + 1;
        exp_q[p].push_back(e);
        acc[p] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  logic [9:0] rt_f[5];
  logic [2:0] rt_r[5];
  logic [9:0] fl[4];
  int         base[4];
  int         nacc[4];

  initial begin
    rt_f = '{10'b10_01_000101, 10'b00_01_000001, 10'b01_10_101100, 10'b01_00_111100, 10'b01_01_111111};
    rt_r = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd4};
    for (int p = 0; p < 4; p++) begin
      tin[p] = '0; tvld[p] = 1'b0; tordy[p] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_ovld_p%0d", p), 32'(tovld[p]), 32'd0);
      chk($sformatf("rst_ty_p%0d", p), 32'(tty[p]), 32'd0);
      chk($sformatf("rst_route_p%0d", p), 32'(trte[p]), 32'd0);
      chk($sformatf("rst_irdy_p%0d", p), 32'(tirdy[p]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int p = 0; p < 4; p++) chk($sformatf("rel_irdy_p%0d", p), 32'(tirdy[p]), 32'd1);
    @(negedge clk);

    // Routing table on w
    chk_lat = 1'b1;
    for (int p = 0; p < 4; p++) tordy[p] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tin[3] = rt_f[i]; tvld[3] = 1'b1;
      tick();
      tvld[3] = 1'b0;
      tick();
      chk($sformatf("route_tbl_%0d", i), 32'(bus.w_route), 32'(rt_r[i]));
      chk($sformatf("wty_tbl_%0d", i), 32'(bus.wty), 32'(rt_f[i]));
    end
    chk_lat = 1'b0;

    // Backpressure on e
    tordy[2] = 1'b0;
    for (int i = 0; i < 4; i++) fl[i] = 10'($urandom);
    for (int i = 0; i < 3; i++) begin
      tin[2] = fl[i]; tvld[2] = 1'b1;
      tick();
      chk($sformatf("bp_acc_%0d", i), 32'(acc[2]), 32'd1);
    end
    chk("bp_irdy_full", 32'(tirdy[2]), 32'd0);
    chk("bp_ovld", 32'(tovld[2]), 32'd1);
    chk("bp_head", 32'(tty[2]), 32'(fl[0]));
    tin[2] = fl[3];
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("bp_refuse_%0d", i), 32'(acc[2]), 32'd0);
    end
    chk("bp_hold", 32'(tty[2]), 32'(fl[0]));
    tvld[2] = 1'b0; tordy[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_stream_vld_%0d", i), 32'(tovld[2]), 32'd1);
      chk($sformatf("bp_stream_ty_%0d", i), 32'(tty[2]), 32'(fl[i]));
      tick();
    end
    chk("bp_empty", 32'(tovld[2]), 32'd0);

    // Full boundary on n: simultaneous pop and refused push
    tordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tin[0] = 10'($urandom); tvld[0] = 1'b1;
      tick();
    end
    chk("full_irdy", 32'(tirdy[0]), 32'd0);
    tin[0] = 10'($urandom); tordy[0] = 1'b1;
    tick();
    chk("full_push_refused", 32'(acc[0]), 32'd0);
    chk("full_irdy_after_pop", 32'(tirdy[0]), 32'd1);
    tick();
    chk("full_push_next", 32'(acc[0]), 32'd1);
    tvld[0] = 1'b0;
    repeat (5) tick();
    chk("full_drained", 32'(exp_q[0].size()), 32'd0);

    // Reset mid-stream with two flits buffered on n
    tordy[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tin[0] = 10'($urandom) | 10'h1; tvld[0] = 1'b1;
      tick();
    end
    tvld[0] = 1'b0;
    chk("mid_pre_ovld", 32'(tovld[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ovld", 32'(tovld[0]), 32'd0);
    chk("mid_nty", 32'(tty[0]), 32'd0);
    chk("mid_irdy", 32'(tirdy[0]), 32'd0);
    for (int p = 0; p < 4; p++) exp_q[p].delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_irdy", 32'(tirdy[0]), 32'd1);
    tordy[0] = 1'b1;
    @(negedge clk);
    tick();
    tick();
    chk("mid_fifo_empty", 32'(tovld[0]), 32'd0);

    // Streaming: all ports, 20 flits each, one-cycle latency
    chk_lat = 1'b1;
    for (int p = 0; p < 4; p++) begin
      base[p] = out_cnt[p]; nacc[p] = 0; tordy[p] = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      for (int p = 0; p < 4; p++) begin
        tin[p] = 10'($urandom); tvld[p] = 1'b1;
      end
      tick();
      for (int p = 0; p < 4; p++) if (!acc[p]) nacc[p]++;
    end
    for (int p = 0; p < 4; p++) tvld[p] = 1'b0;
    repeat (3) tick();
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("stream_refused_p%0d", p), 32'(nacc[p]), 32'd0);
      chk($sformatf("stream_count_p%0d", p), 32'(out_cnt[p] - base[p]), 32'd20);
    end
    chk_lat = 1'b0;

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 4; p++) begin
        tin[p]   = 10'($urandom);
        tvld[p]  = ($urandom_range(0, 9) < 7);
        tordy[p] = ($urandom_range(0, 9) < 6);
      end
      tick();
    end
    for (int p = 0; p < 4; p++) begin
      tvld[p] = 1'b0; tordy[p] = 1'b1;
    end
    repeat (6) tick();
    for (int p = 0; p < 4; p++) chk($sformatf("rand_drained_p%0d", p), 32'(exp_q[p].size()), 32'd0);

`ifdef PIPELINE_ONE_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("stats_reset", 32'(tfwd[1]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tin[1] = 10'($urandom); tvld[1] = 1'b1;
      tick();
    end
    tvld[1] = 1'b0;
    repeat (3) tick();
    chk("stats_five", 32'(tfwd[1]), 32'd5);
    tvld[1] = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      tin[1] = 10'($urandom);
      tick();
    end
    tvld[1] = 1'b0;
    repeat (3) tick();
    chk("stats_saturate", 32'(tfwd[1]), 32'h0000FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
